add3_3_arb: RTL



---
 rtl/add3_3_arb.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/add3_3_arb.sv
`default_nettype none
// ============================================================================
// Module   : add3_3_arb
// Purpose  : Round-robin scheduler that shares one enable-stalled, pipelined
//            3x3 window adder tree between pNUM_REQ requesters. Tracks the
//            in-flight windows with a tag pipeline kept in lockstep with the
//            tree stages and returns each sum with its requester ID over a
//            valid/ready result port.
// Options  : ADD3_3_ARB_STATS_EN adds saturating issue/stall counters with a
//            synchronous clear input.
// Revision : 1.0 - initial release
// ============================================================================
module add3_3_arb #(
  parameter int pDATA_W  = 8,
  parameter int pNUM_REQ = 4,
  parameter int pLAT     = 4
) (
  input  logic                              iclk,
  input  logic                              irst_n,
  input  logic [pNUM_REQ-1:0]               ireq_valid,
  input  logic [pNUM_REQ*9*pDATA_W-1:0]     ireq_data,
  output logic [pNUM_REQ-1:0]               oreq_ready,
  output logic                              otree_en,
  output logic [9*pDATA_W-1:0]              otree_data,
  input  logic [2*pDATA_W-1:0]              itree_sum,
  output logic                              ores_valid,
  output logic [$clog2(pNUM_REQ)-1:0]       ores_id,
  output logic [2*pDATA_W-1:0]              ores_data,
  input  logic                              ires_ready
`ifdef ADD3_3_ARB_STATS_EN
  ,
  input  logic                              istat_clr,
  output logic [31:0]                       ostat_issue_cnt,
  output logic [31:0]                       ostat_stall_cnt
`endif
);

  localparam int                 c_ID_W     = $clog2(pNUM_REQ);
  localparam logic [c_ID_W-1:0]  c_LAST_RST = c_ID_W'(pNUM_REQ - 1);

  // Tag pipeline mirrors the tree stages: valid bit and requester ID per stage.
  logic [pLAT-1:0]    tag_v_q;
  logic [pLAT-1:0]    tag_v_d;
  logic [c_ID_W-1:0]  tag_id_q [pLAT];
  logic [c_ID_W-1:0]  last_grant_q;
  logic [c_ID_W-1:0]  last_grant_d;

  logic               adv;
  logic               grant_found;
  logic [c_ID_W-1:0]  grant_id;
  logic               xfer;

  // Per-requester window view of the flat request data bus.
  logic [9*pDATA_W-1:0] req_win [pNUM_REQ];

  genvar r;
  generate
    for (r = 0; r < pNUM_REQ; r++) begin : g_unpack
      assign req_win[r] = ireq_data[r*9*pDATA_W +: 9*pDATA_W];
    end
  endgenerate

  // Bubbles in the tail always move, so only a held result can stall the tree.
  assign adv        = ~tag_v_q[pLAT-1] | ires_ready;
  assign otree_en   = adv;
  assign xfer       = adv & grant_found;

  assign ores_valid = tag_v_q[pLAT-1];
  assign ores_id    = tag_id_q[pLAT-1];
  assign ores_data  = itree_sum;

  // Round-robin search starting just after the last granted requester.
  always_comb begin : p_arb
    int                idx;
    logic [c_ID_W-1:0] idx_id;
    grant_found = 1'b0;
    grant_id    = '0;
    idx         = 0;
    idx_id      = '0;
    for (int off = 1; off <= pNUM_REQ; off++) begin
      idx = int'(last_grant_q) + off;
      if (idx >= pNUM_REQ) begin
        idx = idx - pNUM_REQ;
      end
      idx_id = idx[c_ID_W-1:0];
      if (!grant_found && ireq_valid[idx_id]) begin
        grant_found = 1'b1;
        grant_id    = idx_id;
      end
    end
  end

  // Grant decode, tree input mux and next-state for the tag/priority state.
  always_comb begin
    oreq_ready   = '0;
    otree_data   = '0;
    tag_v_d      = {tag_v_q[pLAT-2:0], xfer};
    last_grant_d = last_grant_q;
    if (xfer) begin
      oreq_ready[grant_id] = 1'b1;
      otree_data           = req_win[grant_id];
      last_grant_d         = grant_id;
    end
  end

  // Tag pipeline and priority pointer advance only together with the tree.
  always_ff @(posedge iclk) begin
    if (!irst_n) begin
      tag_v_q      <= '0;
      last_grant_q <= c_LAST_RST;
      for (int k = 0; k < pLAT; k++) begin
        tag_id_q[k] <= '0;
      end
    end else if (adv) begin
      tag_v_q      <= tag_v_d;
      last_grant_q <= last_grant_d;
      tag_id_q[0]  <= grant_id;
      for (int k = 1; k < pLAT; k++) begin
        tag_id_q[k] <= tag_id_q[k-1];
      end
    end
  end

`ifdef ADD3_3_ARB_STATS_EN
  logic [31:0] issue_cnt_q;
  logic [31:0] stall_cnt_q;

  // Saturating transfer and result-stall counters; clear wins over counting.
  always_ff @(posedge iclk) begin
    if (!irst_n || istat_clr) begin
      issue_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (xfer && !(&issue_cnt_q)) begin
        issue_cnt_q <= issue_cnt_q + 32'd1;
      end
      if (tag_v_q[pLAT-1] && !ires_ready && !(&stall_cnt_q)) begin
        stall_cnt_q <= stall_cnt_q + 32'd1;
      end
    end
  end

  assign ostat_issue_cnt = issue_cnt_q;
  assign ostat_stall_cnt = stall_cnt_q;
`endif

endmodule
`default_nettype wire
